// File: rtl/nn_weight_sink.sv
// nn_weight_sink: per-layer receiver for the 32-bit weight broadcast bus {id, value}.
// Collects each neuron's burst of weights+bias into a local store and tracks completion.
module nn_weight_sink #(
  parameter int  LAYER_BIT  = 1,
  parameter int  N_GROUPS   = 3,
  parameter int  GROUP_SIZE = 20,
  parameter int  N_WEIGHTS  = 7,
  localparam int N_NEURONS  = N_GROUPS * GROUP_SIZE,
  localparam int NW         = $clog2(N_WEIGHTS),
  localparam int NN         = $clog2(N_NEURONS)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [31:0]   w_tdata,
  input  logic [15:0]   set_in,
  input  logic          set_en,
  output logic [1:0]    mode,
  input  logic [NN-1:0] rd_neuron,
  input  logic [NW-1:0] rd_index,
  output logic [15:0]   rd_data,
  output logic [NN:0]   loaded_cnt,
  output logic          load_done,
  output logic          err_overflow,
  output logic          err_short,
  output logic          err_range
);

  localparam int DEPTH = N_NEURONS * N_WEIGHTS;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(N_WEIGHTS + 1);
  localparam logic [7:0]    LAYER_ID = 8'(1 << LAYER_BIT);
  localparam logic [PW-1:0] PTR_FULL = PW'(N_WEIGHTS);

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_LOAD = 2'd2
  } mode_e;

  function automatic logic [AW-1:0] addr_of(input logic [NN-1:0] n, input int i);
    return AW'(int'(n) * N_WEIGHTS + i);
  endfunction

  mode_e                mode_q, mode_d;
  logic                 mode_wr;
  logic [31:0]          w_q;
  logic                 prev_hit_q, prev_hit_d;
  logic [15:0]          prev_id_q, prev_id_d;
  logic [NN-1:0]        prev_n_q, prev_n_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 ovf_q, ovf_d;
  logic [N_NEURONS-1:0] loaded_q, loaded_d;
  logic [NN:0]          cnt_q, cnt_d;
  logic                 err_ovf_q, err_ovf_d;
  logic                 err_short_q, err_short_d;
  logic                 err_range_q, err_range_d;
  logic [15:0]          rd_data_q;

  logic [15:0]   store_mem [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;

  // Stage-1 decode of the registered bus word
  logic [15:0]   id;
  logic [2:0]    grp_j;
  logic [4:0]    nrn_k;
  logic          layer_match, in_range, hit, range_hit, cont, burst_end, complete;
  logic [NN-1:0] n_cur;

  assign id          = w_q[31:16];
  assign grp_j       = w_q[23:21];
  assign nrn_k       = w_q[20:16];
  assign layer_match = (mode_q == MODE_LOAD) && (w_q[31:24] == LAYER_ID);
  assign in_range    = (int'(grp_j) < N_GROUPS) && (int'(nrn_k) < GROUP_SIZE);
  assign hit         = layer_match && in_range;
  assign range_hit   = layer_match && !in_range;
  assign n_cur       = NN'(int'(grp_j) * GROUP_SIZE + int'(nrn_k));
  assign cont        = hit && prev_hit_q && (id == prev_id_q);
  assign burst_end   = prev_hit_q && !cont;
  assign complete    = (ptr_q == PTR_FULL) && !ovf_q;

  always_comb begin
    mode_d  = mode_q;
    mode_wr = 1'b0;
    if (set_en) begin
      if (set_in == 16'd2) begin
        mode_d  = MODE_LOAD;
        mode_wr = 1'b1;
      end else if (set_in == 16'd1) begin
        mode_d  = MODE_RUN;
        mode_wr = 1'b1;
      end
    end
  end

  always_comb begin
    prev_hit_d  = prev_hit_q;
    prev_id_d   = prev_id_q;
    prev_n_d    = prev_n_q;
    ptr_d       = ptr_q;
    ovf_d       = ovf_q;
    loaded_d    = loaded_q;
    cnt_d       = cnt_q;
    err_ovf_d   = err_ovf_q;
    err_short_d = err_short_q;
    err_range_d = err_range_q;
    we          = 1'b0;
    waddr       = '0;
    if (mode_wr) begin
      // A valid mode write abandons any burst in flight without touching its flag
      prev_hit_d = 1'b0;
      ptr_d      = '0;
      ovf_d      = 1'b0;
      if (mode_d == MODE_LOAD) begin
        loaded_d    = '0;
        cnt_d       = '0;
        err_ovf_d   = 1'b0;
        err_short_d = 1'b0;
        err_range_d = 1'b0;
      end
    end else begin
      if (burst_end) begin
        if (complete) begin
          if (!loaded_q[prev_n_q]) cnt_d = cnt_q + 1'b1;
          loaded_d[prev_n_q] = 1'b1;
        end else begin
          if (loaded_q[prev_n_q]) cnt_d = cnt_q - 1'b1;
          loaded_d[prev_n_q] = 1'b0;
          if (ptr_q < PTR_FULL) err_short_d = 1'b1;
        end
      end
      if (range_hit) err_range_d = 1'b1;
      prev_hit_d = hit;
      prev_id_d  = id;
      prev_n_d   = n_cur;
      if (hit && !cont) begin
        we    = 1'b1;
        waddr = addr_of(n_cur, 0);
        ptr_d = PW'(1);
        ovf_d = 1'b0;
      end else if (cont) begin
        if (ptr_q < PTR_FULL) begin
          we    = 1'b1;
          waddr = addr_of(n_cur, int'(ptr_q));
          ptr_d = ptr_q + 1'b1;
        end else begin
          ovf_d     = 1'b1;
          err_ovf_d = 1'b1;
        end
      end else begin
        ptr_d = '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q      <= MODE_IDLE;
      w_q         <= '0;
      prev_hit_q  <= 1'b0;
      prev_id_q   <= '0;
      prev_n_q    <= '0;
      ptr_q       <= '0;
      ovf_q       <= 1'b0;
      loaded_q    <= '0;
      cnt_q       <= '0;
      err_ovf_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_range_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      mode_q      <= mode_d;
      w_q         <= w_tdata;
      prev_hit_q  <= prev_hit_d;
      prev_id_q   <= prev_id_d;
      prev_n_q    <= prev_n_d;
      ptr_q       <= ptr_d;
      ovf_q       <= ovf_d;
      loaded_q    <= loaded_d;
      cnt_q       <= cnt_d;
      err_ovf_q   <= err_ovf_d;
      err_short_q <= err_short_d;
      err_range_q <= err_range_d;
      if ((int'(rd_index) < N_WEIGHTS) && (int'(rd_neuron) < N_NEURONS))
        rd_data_q <= store_mem[addr_of(rd_neuron, int'(rd_index))];
      else
        rd_data_q <= '0;
    end
  end

  // Store is not reset; the loaded flags say which entries are meaningful
  always_ff @(posedge aclk) begin
    if (we) store_mem[waddr] <= w_q[15:0];
  end

  assign mode         = mode_q;
  assign rd_data      = rd_data_q;
  assign loaded_cnt   = cnt_q;
  assign load_done    = (cnt_q == (NN + 1)'(N_NEURONS));
  assign err_overflow = err_ovf_q;
  assign err_short    = err_short_q;
  assign err_range    = err_range_q;

endmodule
